// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction ROM port, redirect input from execute,
// and the valid/ready instruction channel to decode.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            ir_valid;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] ir_pc;
    logic [2:0]      ir_class;
    logic            ir_ready;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc, ir_class,
        input  imem_rdata, redirect_valid, redirect_pc, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc, ir_class,
        output imem_rdata, redirect_valid, redirect_pc, ir_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, one-deep ROM request tracking with an
// epoch tag, and a small prefetch FIFO presented to decode via valid/ready.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic            epoch_reg, epoch_next;
    logic            inflight_reg;
    logic            tag_epoch_reg;
    logic [XLEN-1:0] tag_pc_reg;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]   count_reg, count_next;

    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic            issue;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [XLEN-1:0] head_data;

    assign head_valid = (count_reg != '0);
    assign head_data  = data_mem[rd_ptr_reg];

    // The in-flight word is counted so a full FIFO can never be overrun.
    assign issue = !rst && !bus.redirect_valid &&
                   (({1'b0, count_reg} + (CW+1)'(inflight_reg)) < (CW+1)'(DEPTH));
    assign push  = inflight_reg && (tag_epoch_reg == epoch_reg) && !bus.redirect_valid;
    assign pop   = head_valid && bus.ir_ready;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        epoch_next    = epoch_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        if (bus.redirect_valid) begin
            // Flush wins over a concurrent pop; decode already owns that word.
            fetch_pc_next = bus.redirect_pc & ALIGN_MASK;
            epoch_next    = ~epoch_reg;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (issue) fetch_pc_next = fetch_pc_reg + PC_STEP;
            if (push)  wr_ptr_next   = wr_ptr_reg + PW'(1);
            if (pop)   rd_ptr_next   = rd_ptr_reg + PW'(1);
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg  <= RESET_PC;
            epoch_reg     <= 1'b0;
            inflight_reg  <= 1'b0;
            tag_epoch_reg <= 1'b0;
            tag_pc_reg    <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            epoch_reg    <= epoch_next;
            inflight_reg <= issue;
            if (issue) begin
                tag_epoch_reg <= epoch_reg;
                tag_pc_reg    <= fetch_pc_reg;
            end
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end else if (wr_en[i]) begin
                data_mem[i] <= bus.imem_rdata;
                pc_mem[i]   <= tag_pc_reg;
            end
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_reg;
    assign bus.ir_valid  = head_valid;
    assign bus.ir        = head_data;
    assign bus.ir_pc     = pc_mem[rd_ptr_reg];
    assign bus.ir_class  = head_data[XLEN-1 -: 3];
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ROM, scoreboard of expected accepted PCs,
// and one task per scenario with cycle-exact handshake/request checks.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks_count = 0;
    int   errors_count = 0;
    logic [31:0] sb_q [$];

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Synchronous ROM: data one cycle after the request.
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? rom_word(bus.imem_addr) : 32'hDEAD_BEEF;

    // Scoreboard: every completed handshake pops one expected PC.
    always @(negedge clk) begin
        if (!rst && bus.ir_valid && bus.ir_ready) begin
            if (sb_q.size() == 0) begin
                checks_count++;
                errors_count++;
                $display("FAIL unexpected_accept: got ir_pc=%h, required no transfer", bus.ir_pc);
            end else begin
                logic [31:0] exp_pc;
                logic [31:0] exp_ir;
                exp_pc = sb_q.pop_front();
                exp_ir = rom_word(exp_pc);
                checks_count++;
                if (bus.ir_pc !== exp_pc) begin
                    errors_count++;
                    $display("FAIL accept_pc: got %h, required %h", bus.ir_pc, exp_pc);
                end
                checks_count++;
                if (bus.ir !== exp_ir) begin
                    errors_count++;
                    $display("FAIL accept_ir: pc %h got %h, required %h", exp_pc, bus.ir, exp_ir);
                end
                checks_count++;
                if (bus.ir_class !== exp_ir[31:29]) begin
                    errors_count++;
                    $display("FAIL accept_class: got %0d, required %0d", bus.ir_class, exp_ir[31:29]);
                end
                $display("accept pc=%h ir=%h class=%0d", bus.ir_pc, bus.ir, bus.ir_class);
            end
        end
    end

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(start + 32'(4 * i));
    endtask

    // Holds rst for two edges, then releases it; returns inside cycle 0.
    task automatic do_reset(input logic rdy);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.ir_ready = rdy;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin ok = 1'b1; break; end
        end
        bus.ir_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks_count++;
        if ({bus.ir_valid, bus.imem_req} !== 2'b00) begin
            errors_count++;
            $display("FAIL reset_flags: got valid=%b req=%b, required 0 0", bus.ir_valid, bus.imem_req);
        end
        checks_count++;
        if ({bus.ir, bus.ir_pc} !== 64'h0) begin
            errors_count++;
            $display("FAIL reset_ir: got ir=%h pc=%h, required 0 0", bus.ir, bus.ir_pc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checks_count++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.ir_valid !== 1'b0) begin
            errors_count++;
            $display("FAIL reset_first_req: got req=%b addr=%h valid=%b, required 1 0 0",
                     bus.imem_req, bus.imem_addr, bus.ir_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        bit ok;
        do_reset(1'b1);
        push_stream(32'h0, 16);
        for (int c = 0; c < 18; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk); #1;
            checks_count++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * c)) begin
                errors_count++;
                $display("FAIL stream_req c%0d: got req=%b addr=%h, required 1 %h",
                         c, bus.imem_req, bus.imem_addr, 32'(4 * c));
            end
            checks_count++;
            if (bus.ir_valid !== (c >= 2)) begin
                errors_count++;
                $display("FAIL stream_valid c%0d: got %b, required %b", c, bus.ir_valid, c >= 2);
            end
        end
        drain(4, ok);
        checks_count++;
        if (!ok) begin errors_count++; $display("FAIL stream_drain: got %0d left, required 0", sb_q.size()); end
        $display("test_stream done");
    endtask

    task automatic test_full();
        bit ok;
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk); #1;
            checks_count++;
            if (bus.imem_req !== (c < 4) || (c < 4 && bus.imem_addr !== 32'(4 * c))) begin
                errors_count++;
                $display("FAIL full_req c%0d: got req=%b addr=%h, required %b %h",
                         c, bus.imem_req, bus.imem_addr, c < 4, 32'(4 * c));
            end
            if (c >= 2) begin
                checks_count++;
                if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 32'h0 || bus.ir !== rom_word(32'h0)) begin
                    errors_count++;
                    $display("FAIL full_hold c%0d: got valid=%b pc=%h ir=%h, required 1 0 %h",
                             c, bus.ir_valid, bus.ir_pc, bus.ir, rom_word(32'h0));
                end
            end
        end
        for (int c = 10; c < 22; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin bus.ir_ready = 1'b1; push_stream(32'h0, 12); end
            @(negedge clk); #1;
            checks_count++;
            if (bus.ir_valid !== 1'b1) begin
                errors_count++;
                $display("FAIL full_gap c%0d: got valid=%b, required 1", c, bus.ir_valid);
            end
            if (c == 10 || c == 11) begin
                checks_count++;
                if (bus.imem_req !== (c == 11) || (c == 11 && bus.imem_addr !== 32'h10)) begin
                    errors_count++;
                    $display("FAIL full_resume c%0d: got req=%b addr=%h, required %b 10",
                             c, bus.imem_req, bus.imem_addr, c == 11);
                end
            end
        end
        drain(4, ok);
        checks_count++;
        if (!ok) begin errors_count++; $display("FAIL full_drain: got %0d left, required 0", sb_q.size()); end
        $display("test_full done");
    endtask

    // Redirect at cycle r with a live stream; old words before r, then target stream.
    task automatic test_redirect(input int r, input logic [31:0] raw_pc, input int n_new);
        bit ok;
        logic [31:0] tgt;
        tgt = raw_pc & 32'hFFFF_FFFC;
        do_reset(1'b1);
        push_stream(32'h0, r - 1);
        push_stream(tgt, n_new);
        for (int c = 0; c < r + n_new + 3; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            bus.redirect_valid = (c == r);
            bus.redirect_pc    = (c == r) ? raw_pc : 32'h0;
            @(negedge clk); #1;
            if (c == r) begin
                checks_count++;
                if (bus.imem_req !== 1'b0) begin
                    errors_count++;
                    $display("FAIL redir_noreq: got req=%b, required 0", bus.imem_req);
                end
            end
            if (c >= r + 1 && c <= r + 3) begin
                checks_count++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== tgt + 32'(4 * (c - r - 1))) begin
                    errors_count++;
                    $display("FAIL redir_addr c%0d: got req=%b addr=%h, required 1 %h",
                             c, bus.imem_req, bus.imem_addr, tgt + 32'(4 * (c - r - 1)));
                end
                checks_count++;
                if (bus.ir_valid !== (c == r + 3)) begin
                    errors_count++;
                    $display("FAIL redir_valid c%0d: got %b, required %b", c, bus.ir_valid, c == r + 3);
                end
            end
        end
        bus.redirect_valid = 1'b0;
        drain(4, ok);
        checks_count++;
        if (!ok) begin errors_count++; $display("FAIL redir_drain: got %0d left, required 0", sb_q.size()); end
        $display("test_redirect target=%h done", tgt);
    endtask

    task automatic test_redirect_on_accept();
        bit ok;
        do_reset(1'b0);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 6) begin
                bus.ir_ready = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = 32'h202;
                sb_q.push_back(32'h0);
                push_stream(32'h200, 5);
            end else begin
                bus.redirect_valid = 1'b0;
            end
            @(negedge clk); #1;
            if (c == 6) begin
                checks_count++;
                if (bus.ir_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
                    errors_count++;
                    $display("FAIL acc_redir_head: got valid=%b req=%b, required 1 0", bus.ir_valid, bus.imem_req);
                end
            end
            if (c == 7 || c == 8) begin
                checks_count++;
                if (bus.ir_valid !== 1'b0) begin
                    errors_count++;
                    $display("FAIL acc_redir_flush c%0d: got valid=%b, required 0", c, bus.ir_valid);
                end
            end
        end
        drain(4, ok);
        checks_count++;
        if (!ok) begin errors_count++; $display("FAIL acc_redir_drain: got %0d left, required 0", sb_q.size()); end
        $display("test_redirect_on_accept done");
    endtask

    task automatic test_mid_reset();
        bit ok;
        do_reset(1'b0);
        for (int c = 0; c < 13; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            rst = (c == 4);
            if (c == 5) begin bus.ir_ready = 1'b1; push_stream(32'h0, 6); end
            @(negedge clk); #1;
            if (c == 4) begin
                checks_count++;
                if (bus.ir_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
                    errors_count++;
                    $display("FAIL mid_rst_pre: got valid=%b req=%b, required 1 0", bus.ir_valid, bus.imem_req);
                end
            end
            if (c == 5 || c == 6) begin
                checks_count++;
                if (bus.ir_valid !== 1'b0) begin
                    errors_count++;
                    $display("FAIL mid_rst_empty c%0d: got valid=%b, required 0", c, bus.ir_valid);
                end
            end
            if (c == 5) begin
                checks_count++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
                    errors_count++;
                    $display("FAIL mid_rst_restart: got req=%b addr=%h, required 1 0", bus.imem_req, bus.imem_addr);
                end
            end
        end
        drain(4, ok);
        checks_count++;
        if (!ok) begin errors_count++; $display("FAIL mid_rst_drain: got %0d left, required 0", sb_q.size()); end
        $display("test_mid_reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        test_reset();
        test_stream();
        test_full();
        test_redirect(8, 32'h0000_0103, 8);
        test_redirect_on_accept();
        test_redirect(4, 32'hFFFF_FFF8, 6);
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks_count, errors_count);
        $finish;
    end
endmodule
